mat_vec_result_collector: RTL and testbench
===========================================

# mat_vec_result_collector

Receiving end of the matrix-by-vector result path. It accepts per-group result words from the row-by-vector units, one group of `no_of_units` lanes per `read_now` strobe, and places each lane at its equation index in a full-length result vector. Padding rows beyond `no_of_eqn_per_cluster` are dropped, and `finish` is raised once the last group has landed. It sits between the result decoder output of a cluster's matrix-by-vector engine and the Jacobi update logic that consumes the complete vector.

## Interface
- `no_of_eqn_per_cluster`, 3: number of real equations (rows) per cluster.
- `element_width`, 32: width of one result word.
- `no_of_units`, 4: number of lanes per incoming group.
- `NI`, 8: padding granule.
- `additional`, `NI-(no_of_eqn_per_cluster%NI)`: number of padding rows.
- `total`, `no_of_eqn_per_cluster+additional`: padded row count. It must be a multiple of `no_of_units`.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level. High enables collection; low aborts or releases.
- `in_group`, in, `element_width*no_of_units`: one group of results. The MSB lane holds the lowest row of the group.
- `read_now`, in, 1: `in_group` is valid this cycle.
- `collector_ready`, out, 1: the block accepts `read_now` this cycle.
- `out_full`, out, `no_of_eqn_per_cluster*element_width`: assembled vector. The MSB word is row 0.
- `finish`, out, 1: `out_full` is complete and stable.
- `overflow_err`, out, 1: sticky flag. A strobe arrived after completion.

## Operation
- The number of groups is `G = total/no_of_units`. Group `g`, lane `k` (k=0 is the MSB lane) maps to row `r = g*no_of_units + k`.
  - Rows with `r < no_of_eqn_per_cluster` are written to `out_full[element_width*(no_of_eqn_per_cluster-r)-1 -: element_width]`.
  - Rows with `r >= no_of_eqn_per_cluster` are discarded.
- State machine with three states: IDLE, COLLECT, DONE.
- IDLE
  - `collector_ready`=0, `finish`=0.
  - `start`=1 moves to COLLECT. On that edge: `group_cnt`←0, `out_full`←0, `overflow_err`←0.
  - `read_now` is ignored in IDLE and raises no error.
- COLLECT
  - `collector_ready`=1.
  - Each edge with `read_now`=1 writes group `group_cnt`, then `group_cnt`++.
  - If `group_cnt==G-1` at that edge, the block moves to DONE.
  - Back-to-back strobes and gaps of any length are both legal.
- DONE
  - `finish`=1, `collector_ready`=0, `out_full` frozen.
  - `read_now`=1 sets `overflow_err` and the data is discarded.
  - `start`=0 moves to IDLE.
- Abort: `start`=0 in COLLECT moves to IDLE next edge. `finish` stays 0, and `out_full` keeps its partial contents until the next `start`.
- `group_cnt` is wide enough for `G`. No wrap-around in normal operation, because DONE blocks further writes.
- Data is stored unmodified; there is no arithmetic.

## Timing
- Reset (`reset`=0, asynchronous, immediate) forces:
  - state IDLE
  - `group_cnt`=0
  - `out_full`=0
  - `finish`=0
  - `collector_ready`=0
  - `overflow_err`=0
- Reset asserted mid-COLLECT discards all partial data.
- All outputs are registered.
- `collector_ready` rises 1 cycle after the edge that samples `start`=1 in IDLE.
- Capture latency is zero cycles:
  - Words from a strobe are visible on `out_full` after the sampling edge.
  - `finish` rises at the same edge that captures group `G-1`.
- `finish` falls 1 edge after `start` is sampled low.
- Minimum total time: 1 cycle (IDLE→COLLECT) plus `G` strobe cycles.
- `start` falling at the same edge as the final strobe: abort wins. The state goes to IDLE, `finish` stays 0, and the final group is not written.
- `read_now` and `start` rising in the same IDLE cycle: the strobe is ignored.

## Test plan
- Default parameters (G=2):
  - Stimulus: group0 lanes MSB→LSB = 0x11,0x22,0x33,0x44; group1 = 0x55,0x66,0x77,0x88; strobes back-to-back.
  - Required: `out_full` = {0x11,0x22,0x33}; `finish`=1 on the edge capturing group1; `overflow_err`=0.
- `no_of_eqn_per_cluster`=10 (additional=6, total=16, G=4):
  - Stimulus: lane values 1..16 in row order, with 2 idle cycles between strobes.
  - Required: `out_full` = words 1..10 (MSB first); rows 11..16 dropped; `finish` only after the 4th strobe.
- Overflow:
  - Stimulus: in DONE, pulse `read_now` with 0xDEADBEEF in all lanes.
  - Required: `overflow_err`=1; `out_full` unchanged.
  - Then drop and re-raise `start`: `overflow_err`=0 and `out_full`=0 on COLLECT entry.
- Abort:
  - Stimulus: `start`=0 after group0 only.
  - Required: IDLE next edge; `finish` never 1; `out_full` holds {0x11,0x22,0x33}.
  - Then a new `start` clears `out_full` and `group_cnt`.
- Asynchronous reset:
  - Stimulus: `reset`=0 pulsed mid-COLLECT, between clock edges.
  - Required: every output is 0 immediately, before the next edge; collection restarts only on `start`.
- Ignored strobes:
  - Stimulus: `read_now`=1 in IDLE and on the COLLECT-entry edge.
  - Required: nothing written; `group_cnt` stays 0; `overflow_err`=0.

Source files
------------

// File: rtl/mat_vec_result_collector_if.sv
// Result-group handshake between the matrix-by-vector result decoder and the collector.
// The master drives groups; the slave reports when it can take them.
interface mat_vec_result_collector_if #(
    parameter int element_width = 32,
    parameter int no_of_units   = 4
);
    logic [element_width*no_of_units-1:0] in_group;
    logic                                 read_now;
    logic                                 collector_ready;

    modport master (output in_group, output read_now, input collector_ready);
    modport slave  (input in_group, input read_now, output collector_ready);
endinterface

// File: rtl/mat_vec_result_collector.sv
// Assembles per-group row results into the full per-cluster result vector,
// dropping padding rows and flagging strobes that arrive after completion.
module mat_vec_result_collector #(
    parameter int no_of_eqn_per_cluster = 3,
    parameter int element_width         = 32,
    parameter int no_of_units           = 4,
    parameter int NI                    = 8,
    parameter int additional            = NI - (no_of_eqn_per_cluster % NI),
    parameter int total                 = no_of_eqn_per_cluster + additional
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    mat_vec_result_collector_if.slave                     res_if,
    output logic [no_of_eqn_per_cluster*element_width-1:0] out_full,
    output logic                                          finish,
    output logic                                          overflow_err
);
    localparam int G     = total / no_of_units;
    localparam int CNT_W = $clog2(G + 1);
    localparam int VEC_W = no_of_eqn_per_cluster * element_width;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(G - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   group_cnt_q, group_cnt_d;
    logic [VEC_W-1:0]   out_full_q, out_full_d;
    logic               overflow_err_q, overflow_err_d;
    logic               ready_q, ready_d;
    logic               finish_q, finish_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            group_cnt_q    <= '0;
            out_full_q     <= '0;
            overflow_err_q <= 1'b0;
            ready_q        <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            group_cnt_q    <= group_cnt_d;
            out_full_q     <= out_full_d;
            overflow_err_q <= overflow_err_d;
            ready_q        <= ready_d;
            finish_q       <= finish_d;
        end
    end

    // Dropping start always wins, including over a final strobe on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: begin
                if (!start)
                    state_d = IDLE;
                else if (res_if.read_now && group_cnt_q == LAST_GROUP)
                    state_d = DONE;
            end
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        group_cnt_d    = group_cnt_q;
        out_full_d     = out_full_q;
        overflow_err_d = overflow_err_q;
        ready_d        = (state_d == COLLECT);
        finish_d       = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    group_cnt_d    = '0;
                    out_full_d     = '0;
                    overflow_err_d = 1'b0;
                end
            end
            COLLECT: begin
                if (start && res_if.read_now) begin
                    // Only real rows have a slot; padding lanes of the last group fall away.
                    for (int r = 0; r < no_of_eqn_per_cluster; r++) begin
                        if ((r / no_of_units) == int'(group_cnt_q))
                            out_full_d[element_width*(no_of_eqn_per_cluster-r)-1 -: element_width] =
                                res_if.in_group[element_width*(no_of_units-(r % no_of_units))-1 -: element_width];
                    end
                    group_cnt_d = group_cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (res_if.read_now)
                    overflow_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign res_if.collector_ready = ready_q;
    assign out_full               = out_full_q;
    assign finish                 = finish_q;
    assign overflow_err           = overflow_err_q;
endmodule

// File: tb/tb_mat_vec_result_collector.sv
// Directed and randomized checks of the result collector in two sizes:
// 3 equations (2 groups) and 10 equations (4 groups).
module tb_mat_vec_result_collector;
    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    logic [95:0]  out_full_a;
    logic [319:0] out_full_b;
    logic finish_a, finish_b, ovf_a, ovf_b;

    int checks   = 0;
    int failures = 0;

    // Reference state: which rows hold what, how many groups landed, whether armed.
    logic [31:0] mRows [2][16];
    int          mGot [2];
    bit          mActive [2];
    bit          mOvf [2];
    bit          curStart [2];

    mat_vec_result_collector_if #(.element_width(32), .no_of_units(4)) if_a ();
    mat_vec_result_collector_if #(.element_width(32), .no_of_units(4)) if_b ();

    mat_vec_result_collector #(.no_of_eqn_per_cluster(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .res_if(if_a),
        .out_full(out_full_a), .finish(finish_a), .overflow_err(ovf_a)
    );

    mat_vec_result_collector #(.no_of_eqn_per_cluster(10)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .res_if(if_b),
        .out_full(out_full_b), .finish(finish_b), .overflow_err(ovf_b)
    );

    always #5 clk = ~clk;

    function automatic int eqnOf(input int w);
        return (w == 0) ? 3 : 10;
    endfunction

    function automatic int groupsOf(input int w);
        return (w == 0) ? 2 : 4;
    endfunction

    function automatic logic [319:0] expFull(input int w);
        logic [319:0] v;
        v = '0;
        for (int r = 0; r < eqnOf(w); r++)
            v[32*(eqnOf(w)-r)-1 -: 32] = mRows[w][r];
        return v;
    endfunction

    task automatic modelReset();
        for (int w = 0; w < 2; w++) begin
            mActive[w] = 0;
            mGot[w]    = 0;
            mOvf[w]    = 0;
            for (int r = 0; r < 16; r++) mRows[w][r] = '0;
        end
    endtask

    // One clock edge of the collector's behaviour, written from the row-mapping rules.
    task automatic modelEdge(input int w, input bit s, input bit rn, input logic [127:0] grp);
        int r;
        if (!mActive[w]) begin
            if (s) begin
                mActive[w] = 1;
                mGot[w]    = 0;
                mOvf[w]    = 0;
                for (int i = 0; i < 16; i++) mRows[w][i] = '0;
            end
        end else if (!s) begin
            if (rn && mGot[w] == groupsOf(w)) mOvf[w] = 1;
            mActive[w] = 0;
        end else if (rn) begin
            if (mGot[w] == groupsOf(w)) begin
                mOvf[w] = 1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    r = mGot[w] * 4 + k;
                    if (r < eqnOf(w)) mRows[w][r] = grp[32*(4-k)-1 -: 32];
                end
                mGot[w]++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input int w, input string tag);
        logic [319:0] expReady, expFin, expOvf;
        expReady = 320'(mActive[w] && mGot[w] < groupsOf(w));
        expFin   = 320'(mActive[w] && mGot[w] == groupsOf(w));
        expOvf   = 320'(mOvf[w]);
        if (w == 0) begin
            checkOutput({tag, ".a.out_full"}, 320'(out_full_a), expFull(0));
            checkOutput({tag, ".a.finish"}, 320'(finish_a), expFin);
            checkOutput({tag, ".a.ready"}, 320'(if_a.collector_ready), expReady);
            checkOutput({tag, ".a.overflow"}, 320'(ovf_a), expOvf);
        end else begin
            checkOutput({tag, ".b.out_full"}, out_full_b, expFull(1));
            checkOutput({tag, ".b.finish"}, 320'(finish_b), expFin);
            checkOutput({tag, ".b.ready"}, 320'(if_b.collector_ready), expReady);
            checkOutput({tag, ".b.overflow"}, 320'(ovf_b), expOvf);
        end
    endtask

    // Drives one DUT for one cycle while the other holds start with no strobe.
    task automatic applyStimulus(input int w, input bit s, input bit rn, input logic [127:0] grp);
        if (w == 0) begin
            start_a = s; if_a.read_now = rn; if_a.in_group = grp; if_b.read_now = 1'b0;
        end else begin
            start_b = s; if_b.read_now = rn; if_b.in_group = grp; if_a.read_now = 1'b0;
        end
        curStart[w] = s;
        @(posedge clk);
        modelEdge(w, s, rn, grp);
        modelEdge(1 - w, curStart[1-w], 1'b0, '0);
        #1;
    endtask

    function automatic logic [127:0] randGroup();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] g0, g1, gb;

    initial begin
        reset = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        if_a.read_now = 1'b0; if_a.in_group = '0;
        if_b.read_now = 1'b0; if_b.in_group = '0;
        curStart[0] = 0; curStart[1] = 0;
        modelReset();
        #12;
        checkDut(0, "reset");
        checkDut(1, "reset");
        reset = 1'b1;
        @(posedge clk); #1;

        g0 = 128'h00000011_00000022_00000033_00000044;
        g1 = 128'h00000055_00000066_00000077_00000088;

        applyStimulus(0, 0, 1, randGroup());  checkDut(0, "idle_strobe");
        applyStimulus(0, 1, 1, randGroup());  checkDut(0, "entry_strobe");
        applyStimulus(0, 1, 1, g0);           checkDut(0, "group0");
        applyStimulus(0, 1, 1, g1);           checkDut(0, "group1_finish");
        checkOutput("a.vector_literal", 320'(out_full_a), 320'(96'h00000011_00000022_00000033));
        applyStimulus(0, 1, 0, '0);           checkDut(0, "done_hold");
        applyStimulus(0, 1, 1, {4{32'hDEADBEEF}}); checkDut(0, "overflow");
        applyStimulus(0, 0, 0, '0);           checkDut(0, "release");
        applyStimulus(0, 1, 0, '0);           checkDut(0, "restart_clear");

        applyStimulus(0, 1, 1, g0);           checkDut(0, "abort_g0");
        applyStimulus(0, 0, 0, '0);           checkDut(0, "abort_idle");
        applyStimulus(0, 0, 0, '0);           checkDut(0, "abort_hold");
        applyStimulus(0, 1, 0, '0);           checkDut(0, "abort_restart");
        applyStimulus(0, 1, 1, randGroup());  checkDut(0, "restart_group0");
        applyStimulus(0, 0, 1, randGroup());  checkDut(0, "abort_wins_final");
        applyStimulus(0, 0, 0, '0);           checkDut(0, "abort_wins_idle");

        applyStimulus(1, 1, 0, '0);           checkDut(1, "b_enter");
        for (int g = 0; g < 4; g++) begin
            gb = {32'(g*4+1), 32'(g*4+2), 32'(g*4+3), 32'(g*4+4)};
            applyStimulus(1, 1, 1, gb);       checkDut(1, "b_strobe");
            applyStimulus(1, 1, 0, '0);       checkDut(1, "b_gap1");
            applyStimulus(1, 1, 0, '0);       checkDut(1, "b_gap2");
        end
        checkOutput("b.vector_literal", out_full_b,
                    {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10});
        applyStimulus(1, 0, 0, '0);           checkDut(1, "b_release");

        applyStimulus(1, 1, 0, '0);           checkDut(1, "b_reenter");
        applyStimulus(1, 1, 1, randGroup());  checkDut(1, "b_partial");
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkDut(0, "async_reset");
        checkDut(1, "async_reset");
        #1;
        reset = 1'b1;
        applyStimulus(1, 0, 0, '0);           checkDut(1, "post_reset_idle");
        applyStimulus(1, 1, 0, '0);           checkDut(1, "post_reset_start");

        for (int i = 0; i < 400; i++) begin
            int w;
            bit s, rn;
            w  = int'($urandom_range(0, 1));
            s  = ($urandom_range(0, 7) != 0);
            rn = ($urandom_range(0, 1) == 1);
            applyStimulus(w, s, rn, randGroup());
            checkDut(w, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
